// File: rtl/apb_slave_regfile.sv
// APB slave register file: eight RW byte registers, a read-only ID register
// and a saturating error counter, with a configurable number of wait states.
module apb_slave_regfile #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [7:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr
);

  // state  | meaning
  // IDLE   | no transfer in progress, waiting for a setup phase
  // ACCESS | transfer latched, counting wait states until completion
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [7:0] ADDR_ID     = 8'h10;
  localparam logic [7:0] ADDR_ERRCNT = 8'h11;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [7:0]  regs_q [8];
  logic [7:0]  regs_d [8];
  logic [7:0]  errcnt_q, errcnt_d;
  logic [7:0]  rd_val;

  // Unmapped addresses and writes to the read-only ID register are errors.
  function automatic logic addr_error(input logic [7:0] a, input logic wr);
    logic mapped;
    mapped = (a < 8'h08) || (a == ADDR_ID) || (a == ADDR_ERRCNT);
    return !mapped || (wr && (a == ADDR_ID));
  endfunction

  // Completion strobe and error response derived from the latched transfer.
  always_comb begin
    pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
    pslverr = pready && err_q;
  end

  // Read mux over the address map; data is only driven on a clean read completion.
  always_comb begin
    rd_val = 8'h00;
    if (addr_q < 8'h08)            rd_val = regs_q[addr_q[2:0]];
    else if (addr_q == ADDR_ID)    rd_val = ID_VALUE;
    else if (addr_q == ADDR_ERRCNT) rd_val = errcnt_q;
    prdata = (pready && !write_q && !err_q) ? rd_val : 8'h00;
  end

  // Next-state logic: setup capture, wait countdown, completion, abort.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    regs_d   = regs_q;
    errcnt_d = errcnt_q;
    case (state_q)
      IDLE: begin
        // psel with penable already high here is a protocol violation and is ignored
        if (psel && !penable) begin
          state_d = ACCESS;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = 4'(WAIT_STATES);
          err_d   = addr_error(paddr, pwrite);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            if (err_q) begin
              if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
            end else if (write_q) begin
              if (addr_q < 8'h08)              regs_d[addr_q[2:0]] = wdata_q;
              else if (addr_q == ADDR_ERRCNT)  errcnt_d = 8'h00;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that discards any transfer in flight.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 8'h00;
      write_q  <= 1'b0;
      wdata_q  <= 8'h00;
      err_q    <= 1'b0;
      errcnt_q <= 8'h00;
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter: WAIT_STATES, 1, number of pready-low access cycles per transfer (0..15).
REQ-002 SHALL have parameter: ID_VALUE, 8'hA5, constant returned by the ID register.
REQ-003 pclk  input  1  sole clock; all state updates on rising edge.
REQ-004 preset  input  1  reset, synchronous, active-high.
REQ-005 psel  input  1  slave select from APB requester.
REQ-006 penable  input  1  access-phase indicator.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  8  byte address.
REQ-009 pwdata  input  8  write data.
REQ-010 prdata  output  8  read data.
REQ-011 pready  output  1  transfer-complete indicator.
REQ-012 pslverr  output  1  error response, qualified by pready.

Function
REQ-013 SHALL implement address map: 0x00-0x07 REG0-REG7 (RW); 0x10 ID (RO, = ID_VALUE); 0x11 ERRCNT (read = error count, write = clear); all other addresses unmapped.
REQ-014 SHALL use a two-state FSM: IDLE, ACCESS.
REQ-015 IDLE -> ACCESS on an edge sampling psel=1, penable=0 (setup phase); at that edge SHALL latch paddr, pwrite, pwdata, load wait counter with WAIT_STATES, and register error flag per REQ-019.
REQ-016 In ACCESS, edge sampling psel=1, penable=1 with counter != 0: counter decrements, stay in ACCESS.
REQ-017 pready SHALL be combinational: 1 iff state = ACCESS and counter = 0; otherwise 0; with WAIT_STATES=N, pready is low for exactly N access cycles, then high for one.
REQ-018 Edge in ACCESS sampling psel=1, penable=1, pready=1 SHALL complete the transfer -> IDLE.
REQ-019 Error flag SHALL be set for: unmapped address (read or write); write to 0x10.
REQ-020 pslverr SHALL equal pready AND error flag; 0 at all other times.
REQ-021 prdata SHALL equal the addressed register value when pready=1, latched pwrite=0 and error flag=0; 8'h00 otherwise, including errored reads.
REQ-022 Write commit SHALL occur only at the completing edge (REQ-018) with latched pwrite=1 and error flag=0; data = latched pwdata.
REQ-023 Write to 0x11 SHALL clear ERRCNT to 0, no error response.
REQ-024 ERRCNT SHALL increment by 1 at every completing edge with pslverr=1, saturating at 8'hFF (no wrap).
REQ-025 Same-edge completing write to 0x11 and error increment are impossible (single transfer); no priority needed.
REQ-026 Abort: psel=0 sampled while in ACCESS SHALL return FSM to IDLE without commit or ERRCNT change.
REQ-027 Protocol violation: psel=1, penable=1 sampled in IDLE SHALL be ignored (stay IDLE, pready=0).
REQ-028 Back-to-back: a new setup phase in the cycle after a completing edge SHALL be accepted from IDLE with no idle cycle required.
REQ-029 Reads of REG0-7 SHALL reflect all writes committed at earlier edges.

Reset
REQ-030 preset=1 sampled at an edge SHALL force FSM to IDLE, counter 0, error flag 0, REG0-REG7 = 8'h00, ERRCNT = 8'h00, regardless of any transfer in progress.
REQ-031 During and after reset until the next setup phase: pready=0, pslverr=0, prdata=8'h00.
REQ-032 A transfer interrupted by reset SHALL not commit and SHALL not be resumed.

Verification
REQ-033 Reset then read 0x03 (WAIT_STATES=1) -> pready low 1 access cycle, then pready=1, prdata=8'h00, pslverr=0.
REQ-034 Write 8'h5C to 0x02, read 0x02 -> prdata=8'h5C, pslverr=0; REG0,REG1,REG3-7 still 8'h00.
REQ-035 Write 8'h11 to 0x10 -> pslverr=1 on completing cycle; read 0x10 -> 8'hA5; read 0x11 -> 8'h01.
REQ-036 Read 0x40 -> pslverr=1, prdata=8'h00; ERRCNT=8'h02; write 0x11 -> ERRCNT reads 8'h00; 256 errored transfers -> ERRCNT=8'hFF.
REQ-037 WAIT_STATES=3 write 8'hC3 to 0x05, drop psel in 2nd access cycle -> no pready, REG5 stays 8'h00; repeat with preset pulse mid-wait -> same, all outputs 0.
REQ-038 WAIT_STATES=0 back-to-back write 8'h01 to 0x00 then read 0x00 -> pready high in each first access cycle, read returns 8'h01.
